// File: rtl/datapath_ctrl_pkg.sv
// Shared types and encodings for the datapath controller: FSM states, opcode
// fields, ALU/writeback encodings and the decoded-instruction record.
package datapath_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DECODE,
        S_GET_A,
        S_GET_B,
        S_EXEC,
        S_WR_IMM,
        S_WR_REG,
        S_DONE
    } state_t;

    localparam logic [2:0] OPC_MOV = 3'b110;
    localparam logic [2:0] OPC_ALU = 3'b101;

    localparam logic [1:0] OP_MOVI = 2'b10;
    localparam logic [1:0] OP_MOVR = 2'b00;
    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_CMP  = 2'b01;
    localparam logic [1:0] OP_AND  = 2'b10;
    localparam logic [1:0] OP_MVN  = 2'b11;

    localparam logic [1:0] ALU_ADD  = 2'b00;
    localparam logic [1:0] ALU_SUB  = 2'b01;
    localparam logic [1:0] ALU_AND  = 2'b10;
    localparam logic [1:0] ALU_NOTB = 2'b11;

    localparam logic VSEL_C  = 1'b0;
    localparam logic VSEL_IN = 1'b1;

    typedef struct packed {
        logic [2:0] rn;
        logic [2:0] rd;
        logic [1:0] sh;
        logic [2:0] rm;
        logic       legal;
        logic       is_movi;
        logic       needs_a;
        logic       is_cmp;
        logic       asel_zero;
        logic [1:0] aluop;
    } dec_t;

    // First state after decode for a legal instruction.
    function automatic state_t first_state(input dec_t d);
        if (d.is_movi)
            return S_WR_IMM;
        else if (d.needs_a)
            return S_GET_A;
        else
            return S_GET_B;
    endfunction

endpackage

// File: rtl/datapath_controller_decoder.sv
// Combinational instruction decoder: register/shift fields plus legality and
// class flags used by the controller FSM.
module instr_decoder
    import datapath_ctrl_pkg::*;
(
    input  logic [15:0] ir,
    output dec_t        dec
);

    logic [2:0] opc;
    logic [1:0] op;

    assign opc = ir[15:13];
    assign op  = ir[12:11];

    always_comb begin
        dec    = '0;
        dec.rn = ir[10:8];
        dec.rd = ir[7:5];
        dec.sh = ir[4:3];
        dec.rm = ir[2:0];

        if (opc == OPC_MOV && op == OP_MOVI) begin
            dec.legal   = 1'b1;
            dec.is_movi = 1'b1;
        end else if (opc == OPC_MOV && op == OP_MOVR) begin
            dec.legal     = 1'b1;
            dec.asel_zero = 1'b1;
            dec.aluop     = ALU_ADD;
        end else if (opc == OPC_ALU) begin
            dec.legal = 1'b1;
            case (op)
                OP_ADD: begin
                    dec.needs_a = 1'b1;
                    dec.aluop   = ALU_ADD;
                end
                OP_CMP: begin
                    dec.needs_a = 1'b1;
                    dec.is_cmp  = 1'b1;
                    dec.aluop   = ALU_SUB;
                end
                OP_AND: begin
                    dec.needs_a = 1'b1;
                    dec.aluop   = ALU_AND;
                end
                default: begin
                    dec.asel_zero = 1'b1;
                    dec.aluop     = ALU_NOTB;
                end
            endcase
        end
    end

endmodule

// File: rtl/datapath_controller.sv
// Multi-cycle controller sequencing the register/shift/ALU datapath through
// read, execute and writeback, one instruction at a time.
module datapath_controller
    import datapath_ctrl_pkg::*;
#(
    parameter int IMM_W = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] instr,
    output logic        ready,
    output logic        done,
    output logic        illegal,
    output logic [2:0]  readnum,
    output logic [2:0]  writenum,
    output logic        vsel,
    output logic        loada,
    output logic        loadb,
    output logic        asel,
    output logic        bsel,
    output logic [1:0]  shift,
    output logic [1:0]  ALUop,
    output logic        loadc,
    output logic        loads,
    output logic        write,
    output logic [15:0] datapath_in
);

    state_t      state_q, state_d;
    logic [15:0] ir_q, ir_d;
    dec_t        dec;

    logic        ready_d, done_d, illegal_d;
    logic [2:0]  readnum_d, writenum_d;
    logic        vsel_d, loada_d, loadb_d, asel_d;
    logic [1:0]  shift_d, aluop_d;
    logic        loadc_d, loads_d, write_d;

    logic        ready_q, done_q, illegal_q;
    logic [2:0]  readnum_q, writenum_q;
    logic        vsel_q, loada_q, loadb_q, asel_q;
    logic [1:0]  shift_q, aluop_q;
    logic        loadc_q, loads_q, write_q;

    assign ir_d = (state_q == S_IDLE && start) ? instr : ir_q;

    // Decoding the incoming word on the accepting edge lets legal instructions
    // skip DECODE; that state only holds the one-cycle illegal report.
    instr_decoder u_dec (
        .ir  (ir_d),
        .dec (dec)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (start) state_d = dec.legal ? first_state(dec) : S_DECODE;
            S_DECODE: state_d = dec.legal ? first_state(dec) : S_IDLE;
            S_GET_A:  state_d = S_GET_B;
            S_GET_B:  state_d = S_EXEC;
            S_EXEC:   state_d = dec.is_cmp ? S_DONE : S_WR_REG;
            S_WR_REG: state_d = S_DONE;
            S_WR_IMM: state_d = S_DONE;
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Outputs are computed for the state being entered and then registered.
    always_comb begin
        ready_d    = (state_d == S_IDLE);
        done_d     = (state_d == S_DONE);
        illegal_d  = (state_d == S_DECODE) && !dec.legal;
        readnum_d  = '0;
        writenum_d = '0;
        shift_d    = '0;
        aluop_d    = '0;
        if (state_d != S_IDLE && state_d != S_DECODE) begin
            readnum_d  = (state_d == S_GET_A) ? dec.rn : dec.rm;
            writenum_d = dec.is_movi ? dec.rn : dec.rd;
            shift_d    = dec.sh;
            aluop_d    = dec.aluop;
        end
        loada_d = (state_d == S_GET_A);
        loadb_d = (state_d == S_GET_B);
        asel_d  = (state_d == S_EXEC) && dec.asel_zero;
        loadc_d = (state_d == S_EXEC) && !dec.is_cmp;
        loads_d = (state_d == S_EXEC) && dec.is_cmp;
        write_d = (state_d == S_WR_REG) || (state_d == S_WR_IMM);
        vsel_d  = (state_d == S_WR_IMM) ? VSEL_IN : VSEL_C;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            ir_q       <= '0;
            ready_q    <= 1'b1;
            done_q     <= 1'b0;
            illegal_q  <= 1'b0;
            readnum_q  <= '0;
            writenum_q <= '0;
            vsel_q     <= 1'b0;
            loada_q    <= 1'b0;
            loadb_q    <= 1'b0;
            asel_q     <= 1'b0;
            shift_q    <= '0;
            aluop_q    <= '0;
            loadc_q    <= 1'b0;
            loads_q    <= 1'b0;
            write_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            ir_q       <= ir_d;
            ready_q    <= ready_d;
            done_q     <= done_d;
            illegal_q  <= illegal_d;
            readnum_q  <= readnum_d;
            writenum_q <= writenum_d;
            vsel_q     <= vsel_d;
            loada_q    <= loada_d;
            loadb_q    <= loadb_d;
            asel_q     <= asel_d;
            shift_q    <= shift_d;
            aluop_q    <= aluop_d;
            loadc_q    <= loadc_d;
            loads_q    <= loads_d;
            write_q    <= write_d;
        end
    end

    assign ready       = ready_q;
    assign done        = done_q;
    assign illegal     = illegal_q;
    assign readnum     = readnum_q;
    assign writenum    = writenum_q;
    assign vsel        = vsel_q;
    assign loada       = loada_q;
    assign loadb       = loadb_q;
    assign asel        = asel_q;
    assign bsel        = 1'b0;
    assign shift       = shift_q;
    assign ALUop       = aluop_q;
    assign loadc       = loadc_q;
    assign loads       = loads_q;
    assign write       = write_q;
    assign datapath_in = {{(16 - IMM_W){ir_q[IMM_W-1]}}, ir_q[IMM_W-1:0]};

endmodule

// File: tb/tb_datapath_controller.sv
// Directed self-checking bench for datapath_controller.
module tb_datapath_controller;

    logic        clk;
    logic        reset;
    logic        start;
    logic [15:0] instr;
    logic        ready, done, illegal;
    logic [2:0]  readnum, writenum;
    logic        vsel, loada, loadb, asel, bsel;
    logic [1:0]  shift, ALUop;
    logic        loadc, loads, write;
    logic [15:0] datapath_in;

    int errors = 0;
    int checks = 0;
    bit write_seen = 1'b0;

    datapath_controller #(.IMM_W(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .instr       (instr),
        .ready       (ready),
        .done        (done),
        .illegal     (illegal),
        .readnum     (readnum),
        .writenum    (writenum),
        .vsel        (vsel),
        .loada       (loada),
        .loadb       (loadb),
        .asel        (asel),
        .bsel        (bsel),
        .shift       (shift),
        .ALUop       (ALUop),
        .loadc       (loadc),
        .loads       (loads),
        .write       (write),
        .datapath_in (datapath_in)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (write === 1'b1) write_seen = 1'b1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] enables();
        return {loada, loadb, loadc, loads, write, asel, vsel};
    endfunction

    initial begin
        reset = 1'b1;
        start = 1'b0;
        instr = 16'h0000;
        tick();
        tick();
        chk("rst_ready", {15'd0, ready}, 16'd1);
        chk("rst_enables", {9'd0, enables()}, 16'd0);
        chk("rst_done_ill", {14'd0, done, illegal}, 16'd0);
        chk("rst_dpin", datapath_in, 16'h0000);
        chk("rst_idx", {10'd0, readnum, writenum}, 16'd0);
        chk("rst_bsel", {15'd0, bsel}, 16'd0);
        reset = 1'b0;
        tick();
        chk("idle_ready", {15'd0, ready}, 16'd1);

        // MOVI R0,#-3
        start = 1'b1;
        instr = 16'hD0FD;
        tick();
        start = 1'b0;
        chk("movi_c1_write", {15'd0, write}, 16'd1);
        chk("movi_c1_wnum", {13'd0, writenum}, 16'd0);
        chk("movi_c1_vsel", {15'd0, vsel}, 16'd1);
        chk("movi_c1_dpin", datapath_in, 16'hFFFD);
        chk("movi_c1_ready", {15'd0, ready, done}, 16'd0);
        tick();
        chk("movi_c2_done", {15'd0, done}, 16'd1);
        chk("movi_c2_write", {15'd0, write}, 16'd0);
        tick();
        chk("movi_c3_ready", {14'd0, ready, done}, 16'b10);

        // ADD R2,R1,R0 LSL-style shift 01
        write_seen = 1'b0;
        start = 1'b1;
        instr = 16'hA148;
        tick();
        start = 1'b0;
        chk("add_c1_read", {13'd0, readnum}, 16'd1);
        chk("add_c1_en", {9'd0, enables()}, 16'b1000000);
        chk("add_c1_write_seen", {15'd0, write_seen}, 16'd0);
        tick();
        chk("add_c2_read", {13'd0, readnum}, 16'd0);
        chk("add_c2_en", {9'd0, enables()}, 16'b0100000);
        tick();
        chk("add_c3_alu", {12'd0, ALUop, shift}, 16'b0001);
        chk("add_c3_en", {9'd0, enables()}, 16'b0010000);
        tick();
        chk("add_c4_wnum", {13'd0, writenum}, 16'd2);
        chk("add_c4_en", {9'd0, enables()}, 16'b0000100);
        chk("add_c4_done", {15'd0, done}, 16'd0);
        tick();
        chk("add_c5_done", {15'd0, done}, 16'd1);
        chk("add_dpin", datapath_in, 16'h0048);
        tick();

        // CMP R3,R4
        write_seen = 1'b0;
        start = 1'b1;
        instr = 16'hAB04;
        tick();
        start = 1'b0;
        chk("cmp_c1_read", {13'd0, readnum}, 16'd3);
        chk("cmp_c1_loada", {15'd0, loada}, 16'd1);
        tick();
        chk("cmp_c2_read", {13'd0, readnum}, 16'd4);
        chk("cmp_c2_loadb", {15'd0, loadb}, 16'd1);
        tick();
        chk("cmp_c3_en", {9'd0, enables()}, 16'b0001000);
        chk("cmp_c3_alu", {14'd0, ALUop}, 16'b01);
        tick();
        chk("cmp_c4_done", {15'd0, done}, 16'd1);
        chk("cmp_no_write", {15'd0, write_seen}, 16'd0);
        tick();

        // MVN R5,R6 shift 10
        start = 1'b1;
        instr = 16'hB8B6;
        tick();
        start = 1'b0;
        chk("mvn_c1_read", {13'd0, readnum}, 16'd6);
        chk("mvn_c1_en", {9'd0, enables()}, 16'b0100000);
        tick();
        chk("mvn_c2_alu", {12'd0, ALUop, shift}, 16'b1110);
        chk("mvn_c2_en", {9'd0, enables()}, 16'b0010010);
        tick();
        chk("mvn_c3_wnum", {13'd0, writenum}, 16'd5);
        chk("mvn_c3_en", {9'd0, enables()}, 16'b0000100);
        tick();
        chk("mvn_c4_done", {15'd0, done}, 16'd1);
        tick();

        // MOV R7,R1 shift 11
        start = 1'b1;
        instr = 16'hC0F9;
        tick();
        start = 1'b0;
        chk("mov_c1_read", {13'd0, readnum}, 16'd1);
        chk("mov_c1_en", {9'd0, enables()}, 16'b0100000);
        tick();
        chk("mov_c2_alu", {12'd0, ALUop, shift}, 16'b0011);
        chk("mov_c2_asel", {15'd0, asel}, 16'd1);
        tick();
        chk("mov_c3_wnum", {13'd0, writenum}, 16'd7);
        tick();
        chk("mov_c4_done", {15'd0, done}, 16'd1);
        tick();

        // Illegal opcodes
        start = 1'b1;
        instr = 16'h0000;
        tick();
        start = 1'b0;
        chk("ill0_c1_illegal", {14'd0, illegal, ready}, 16'b10);
        chk("ill0_c1_en", {9'd0, enables()}, 16'd0);
        tick();
        chk("ill0_c2", {13'd0, ready, illegal, done}, 16'b100);
        start = 1'b1;
        instr = 16'hC800;
        tick();
        start = 1'b0;
        chk("ill1_c1_illegal", {15'd0, illegal}, 16'd1);
        tick();
        chk("ill1_c2_ready", {15'd0, ready}, 16'd1);

        // Back-to-back MOVIs with start held high
        start = 1'b1;
        instr = 16'hD0FD;
        tick();
        instr = 16'hD17F;
        chk("b2b_c1_dpin", datapath_in, 16'hFFFD);
        tick();
        chk("b2b_c2_done", {15'd0, done}, 16'd1);
        tick();
        chk("b2b_c3_idle", {13'd0, ready, done, write}, 16'b100);
        tick();
        chk("b2b_c4_write", {15'd0, write}, 16'd1);
        chk("b2b_c4_wnum", {13'd0, writenum}, 16'd1);
        chk("b2b_c4_dpin", datapath_in, 16'h007F);
        chk("b2b_c4_done", {15'd0, done}, 16'd0);
        start = 1'b0;
        tick();
        chk("b2b_c5_done", {15'd0, done}, 16'd1);
        tick();

        // Reset during EXEC of ADD
        write_seen = 1'b0;
        start = 1'b1;
        instr = 16'hA148;
        tick();
        start = 1'b0;
        tick();
        tick();
        chk("rx_exec_loadc", {15'd0, loadc}, 16'd1);
        #2 reset = 1'b1;
        #1;
        chk("rx_async_ready", {15'd0, ready}, 16'd1);
        chk("rx_async_en", {9'd0, enables()}, 16'd0);
        chk("rx_async_dpin", datapath_in, 16'h0000);
        tick();
        chk("rx_edge_ready", {14'd0, ready, done}, 16'b10);
        reset = 1'b0;
        tick();
        tick();
        chk("rx_no_write", {15'd0, write_seen}, 16'd0);
        chk("rx_idle_en", {9'd0, enables()}, 16'd0);
        chk("rx_idle_ready", {15'd0, ready}, 16'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
